// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer: routes i to the channel chosen by {s2,s1,s}.
// Latency: one clk cycle, every output comes straight from a flop.
// Backpressure: none, every rising edge loads a new output vector.
module demux_1x8 (
   input  logic clk,
   input  logic rst_n,
   input  logic i,
   input  logic s,
   input  logic s1,
   input  logic s2,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g,
   output logic h
);

   logic [2:0] w_sel;
   logic [7:0] w_onehot;
   logic [7:0] r_out;

   assign w_sel = {s2, s1, s};

   // Decode select into a one-hot vector carrying i; all other channels are 0.
   always_comb begin
      w_onehot        = 8'h00;
      w_onehot[w_sel] = i;
   end

   // Capture the decoded vector each edge. Reset clears all channels at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 8'h00;
      end else begin
         r_out <= w_onehot;
      end
   end

   assign a = r_out[0];
   assign b = r_out[1];
   assign c = r_out[2];
   assign d = r_out[3];
   assign e = r_out[4];
   assign f = r_out[5];
   assign g = r_out[6];
   assign h = r_out[7];

endmodule

// File: tb/tb_demux_1x8.sv
// Directed and random checks of demux_1x8 against a one-cycle-delayed model.
module tb_demux_1x8;

   logic clk;
   logic rst_n;
   logic i;
   logic s;
   logic s1;
   logic s2;
   logic a, b, c, d, e, f, g, h;
   logic [7:0] out;

   int vectors;
   int miscompares;
   logic [7:0] exp_q[$];
   logic [7:0] last_exp;

   demux_1x8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i     (i),
      .s     (s),
      .s1    (s1),
      .s2    (s2),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .h     (h)
   );

   assign out = {h, g, f, e, d, c, b, a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector for a given input and select value.
   function automatic logic [7:0] model(input logic ii, input logic [2:0] sel);
      logic [7:0] v;
      v = 8'h00;
      if (ii) v[sel] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply inputs now and queue the vector the next edge should produce.
   task automatic drive(input logic ii, input logic [2:0] sel);
      i  = ii;
      {s2, s1, s} = sel;
      exp_q.push_back(model(ii, sel));
   endtask

   // Wait for the edge, then pop and compare (plus the one-hot property).
   task automatic capture(input string tag);
      logic [7:0] exp;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         exp = exp_q.pop_front();
         chk(tag, out, exp);
         chk({tag, "_onehot"}, {7'd0, ($countones(out) <= 1)}, 8'd1);
         last_exp = exp;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_exp    = 8'h00;
      rst_n = 1'b1;
      i = 1'b1;
      {s2, s1, s} = 3'd5;
      #1 rst_n = 1'b0;
      #1 chk("reset_async", out, 8'h00);

      // Clock edges during reset must be ignored even with i=1, sel=5.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 chk("reset_hold", out, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full sweep of {s2,s1,s,i}.
      for (int k = 0; k < 16; k++) begin
         drive(k[0], k[3:1]);
         capture($sformatf("sweep_%0d", k));
      end

      // Latency: output must hold the old vector until the next edge.
      drive(1'b1, 3'd3);
      @(negedge clk);
      chk("latency_before", out, last_exp);
      capture("latency_after");
      chk("latency_d", {7'd0, d}, 8'd1);

      // Mid-cycle select glitch 2 -> 6 -> 2 must be invisible.
      i = 1'b1;
      {s2, s1, s} = 3'd2;
      #2 {s2, s1, s} = 3'd6;
      #1 chk("glitch_mid", out, last_exp);
      #2 drive(1'b1, 3'd2);
      capture("glitch_edge");
      chk("glitch_g", {7'd0, g}, 8'd0);

      // Asynchronous reset while h is high.
      drive(1'b1, 3'd7);
      capture("pre_reset_h");
      #2 rst_n = 1'b0;
      #1 chk("midop_reset", out, 8'h00);
      @(negedge clk);
      chk("midop_reset_hold", out, 8'h00);
      rst_n = 1'b1;
      #1;
      drive(1'b1, 3'd7);
      capture("post_reset_h");

      // Random vectors against the delayed model.
      for (int k = 0; k < 1000; k++) begin
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         capture("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux_1x8.md
DEMUX_1X8 -- requirements
Module: demux_1x8

Interface
REQ-001 The block SHALL have no parameters; widths are fixed.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low; asserted (0) clears all state immediately, independent of clk.
REQ-004 i  input  1  Data bit to be routed.
REQ-005 s  input  1  Select bit 0 (LSB).
REQ-006 s1  input  1  Select bit 1.
REQ-007 s2  input  1  Select bit 2 (MSB).
REQ-008 a  output  1  Channel 0, selected when {s2,s1,s}=3'b000.
REQ-009 b  output  1  Channel 1, selected when {s2,s1,s}=3'b001.
REQ-010 c  output  1  Channel 2, selected when {s2,s1,s}=3'b010.
REQ-011 d  output  1  Channel 3, selected when {s2,s1,s}=3'b011.
REQ-012 e  output  1  Channel 4, selected when {s2,s1,s}=3'b100.
REQ-013 f  output  1  Channel 5, selected when {s2,s1,s}=3'b101.
REQ-014 g  output  1  Channel 6, selected when {s2,s1,s}=3'b110.
REQ-015 h  output  1  Channel 7, selected when {s2,s1,s}=3'b111.

Function
REQ-016 Select index SHALL be sel = {s2,s1,s}, unsigned 0..7, s2 MSB.
REQ-017 On each rising clk edge with rst_n=1, the output of channel sel SHALL register the value of i.
REQ-018 On the same edge, all seven non-selected outputs SHALL register 0.
REQ-019 Outputs SHALL be driven directly from flops; no combinational path from i, s, s1 or s2 to any output.
REQ-020 Latency SHALL be exactly one clk cycle: inputs sampled at edge N appear on outputs after edge N and hold until edge N+1.
REQ-021 At most one output SHALL be 1 at any time; when i=0 all outputs SHALL be 0.
REQ-022 Select changes between edges SHALL have no output effect until the next rising edge; only values at the edge matter.
REQ-023 Simultaneous changes of i and the select bits before an edge SHALL be treated as one new input vector; no intermediate vector is visible.
REQ-024 X/Z on inputs is outside the contract; no recovery behaviour is required beyond reset.
REQ-025 There SHALL be no handshake, enable or backpressure; every edge produces a new output vector.

Reset
REQ-026 While rst_n=0, all outputs a..h SHALL be 0, reached asynchronously at the falling edge of rst_n without waiting for clk.
REQ-027 Clock edges while rst_n=0 SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL clear any active output to 0 immediately.
REQ-029 After rst_n rises, the first rising clk edge SHALL capture inputs normally per REQ-017/018.

Verification
REQ-030 Reset: rst_n=0 with i=1, sel=5 applied and clk toggling -> a..h all 0 throughout.
REQ-031 Full sweep: {s2,s1,s,i} counted 0000 to 1111, one step per clk -> one cycle after each step with i=1, exactly the output indexed by sel (a for 0 through h for 7) is 1; after steps with i=0, all outputs are 0.
REQ-032 Latency: sel=3, i=1 applied just after edge N -> d stays 0 until edge N+1, then d=1 and all others 0.
REQ-033 Mid-cycle glitch: between edges sel switches 2 -> 6 -> 2 with i=1 -> at the next edge only c=1; g never rises.
REQ-034 Async reset mid-operation: h=1 (sel=7, i=1), then rst_n falls between edges -> h drops to 0 before the next clk edge; after release, the next edge with sel=7, i=1 restores h=1.
REQ-035 One-hot check: random {s2,s1,s,i} for at least 1000 cycles -> at most one output is high each cycle and it matches a model delayed by one cycle.
